level_gen_moore_amisha: RTL and testbench
=========================================

# level_gen_moore_amisha

Tick-to-level converter, the companion to the Moore edge detector. It accepts single-cycle tick pulses and regenerates a clean level waveform: each accepted tick drives the level high for a programmable hold time, followed by a mandatory low guard gap. Ticks that arrive while the block is busy are buffered in a one-deep pending slot or reported as overrun. It sits downstream of edge-detect and tick sources, and drives LEDs, enables and strobes that need a minimum-width level.

## Interface
Parameters:
- HOLD, 4: cycles the level stays high per accepted tick (≥1).
- GAP, 2: minimum low cycles between two high intervals (≥1).
- RETRIG, 1: 1 = tick during HIGH reloads the hold counter; 0 = tick during HIGH goes to the pending slot.
- CW, 8: counter width; must satisfy 2^CW > max(HOLD, GAP).

Ports:
- clk_amisha, in, 1: single clock; all logic on the rising edge.
- reset_amisha, in, 1: synchronous, active-low reset.
- tick_amisha, in, 1: input pulse, sampled every rising edge. A multi-cycle high counts as one tick per cycle.
- level_amisha, out, 1: regenerated level. Registered Moore output, high only in HIGH.
- busy_amisha, out, 1: high in HIGH or GUARD. Registered.
- pend_amisha, out, 1: pending slot occupied. Registered.
- overrun_amisha, out, 1: one-cycle pulse when a tick is dropped. Registered.

## Operation
- States: IDLE, HIGH, GUARD. Counter cnt is CW bits; pending flag pend.
- Reset (reset_amisha=0 at an edge):
  - state=IDLE, cnt=0, pend=0.
  - All outputs are 0 from the next cycle.
  - Reset has priority over every other event, including mid-HIGH and mid-GUARD; any pending tick is discarded.
- IDLE:
  - tick → HIGH, cnt=HOLD-1.
  - No tick → stay in IDLE.
- HIGH:
  - tick with RETRIG=1 → cnt=HOLD-1; stay in HIGH.
  - tick with RETRIG=0: if pend=0, set pend=1; if pend=1, pulse overrun_amisha.
  - cnt==0 with no reload → GUARD, cnt=GAP-1.
  - Otherwise cnt decrements.
- GUARD:
  - tick with pend=0 → pend=1.
  - tick with pend=1 → pulse overrun_amisha; the tick is dropped.
  - When cnt==0: if pend=1 or a tick arrives this cycle → HIGH, cnt=HOLD-1, pend=0. Otherwise → IDLE.
  - If cnt==0 and pend=1 and a tick also arrives this cycle: enter HIGH with pend=1 (new tick takes the slot). No overrun.
  - Otherwise cnt decrements.
- Overrun is a single-cycle pulse per dropped tick. Consecutive dropped ticks produce consecutive pulses.
- The counter never wraps. The parameter constraint guarantees HOLD-1 and GAP-1 fit in CW bits.

## Timing
- Tick high in cycle k (sampled at edge k+1) → level_amisha high from cycle k+1, i.e. one cycle of latency.
- Without retrigger, level stays high exactly HOLD cycles, then low for at least GAP cycles.
- RETRIG=1: level falls HOLD cycles after the last tick in the HIGH run.
- Minimum spacing between rising edges of level_amisha: HOLD+GAP cycles.
- Pending service:
  - Level rises again in the cycle right after the last GUARD cycle.
  - No IDLE cycle is inserted.
- busy_amisha, pend_amisha and overrun_amisha update on the same edge as the state change that causes them.

## Test plan
Clock period is 100 ns. All scenarios use HOLD=4, GAP=2 unless stated.
1. Reset check: hold reset_amisha=0 for 2 cycles with tick_amisha=1 → all outputs 0 throughout; no HIGH entry.
2. Single tick: reset deasserted, then one-cycle tick at cycle 3 → level high in cycles 4–7, busy high in cycles 4–9, returns to IDLE at cycle 10, overrun never asserts.
3. Retrigger (RETRIG=1): ticks at cycles 3 and 6 → level high in cycles 4–10 continuously, then GUARD in 11–12.
4. Pending (RETRIG=0): ticks at 3 and 5 → level high 4–7, low 8–9, high again 10–13, pend high 6–9.
5. Overrun (RETRIG=0): ticks at 3, 5, 6 → pend set at 6, overrun pulse in cycle 7 only, level pattern identical to scenario 4.
6. Reset mid-operation: tick at 3, reset_amisha=0 at cycle 5 → level, busy and pend all 0 from cycle 6; a tick at cycle 8 after reset release restarts cleanly with level high 9–12.

Source files
------------

// File: rtl/level_gen_moore_amisha.sv
// ==== level_gen_moore_amisha : tick-to-level converter, HOLD-cycle high + GAP-cycle guard ====
// ==== with a one-deep pending slot and overrun pulse.                  Rev 1.0 ====
`default_nettype none

module level_gen_moore_amisha #(
  parameter int HOLD   = 4,
  parameter int GAP    = 2,
  parameter int RETRIG = 1,
  parameter int CW     = 8
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  input  logic tick_amisha,
  output logic level_amisha,
  output logic busy_amisha,
  output logic pend_amisha,
  output logic overrun_amisha
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk_amisha) begin
    if (!reset_amisha) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_amisha) begin
          state_d = ST_HIGH;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HIGH: begin
        // Without retrigger a tick during HIGH is queued, or dropped if the slot is full.
        if (tick_amisha && (RETRIG == 0)) begin
          if (!pend_q) pend_d = 1'b1;
          else         ovr_d  = 1'b1;
        end
        if (tick_amisha && (RETRIG != 0)) begin
          cnt_d = HOLD_LD;
        end else if (cnt_q == '0) begin
          state_d = ST_GUARD;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          // A fresh tick on the last guard cycle takes over the slot being serviced.
          if (pend_q || tick_amisha) begin
            state_d = ST_HIGH;
            cnt_d   = HOLD_LD;
            pend_d  = pend_q && tick_amisha;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (tick_amisha) begin
            if (!pend_q) pend_d = 1'b1;
            else         ovr_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
    level_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
  end

  assign level_amisha   = level_q;
  assign busy_amisha    = busy_q;
  assign pend_amisha    = pend_q;
  assign overrun_amisha = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_level_gen_moore_amisha.sv
// ==== tb_level_gen_moore_amisha : checks a RETRIG=1 and a RETRIG=0 instance against a  ====
// ==== timestamp-based reference model.                                      Rev 1.0 ====
`timescale 1ns/1ps
`default_nettype none

module tb_level_gen_moore_amisha;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rstn;
  logic tick;
  logic lvl_r, busy_r, pend_r, ovr_r;
  logic lvl_p, busy_p, pend_p, ovr_p;

  always #50 clk = ~clk;

  level_gen_moore_amisha #(.HOLD(HOLD), .GAP(GAP), .RETRIG(1), .CW(CW)) u_retrig (
    .clk_amisha    (clk),
    .reset_amisha  (rstn),
    .tick_amisha   (tick),
    .level_amisha  (lvl_r),
    .busy_amisha   (busy_r),
    .pend_amisha   (pend_r),
    .overrun_amisha(ovr_r)
  );

  level_gen_moore_amisha #(.HOLD(HOLD), .GAP(GAP), .RETRIG(0), .CW(CW)) u_queue (
    .clk_amisha    (clk),
    .reset_amisha  (rstn),
    .tick_amisha   (tick),
    .level_amisha  (lvl_p),
    .busy_amisha   (busy_p),
    .pend_amisha   (pend_p),
    .overrun_amisha(ovr_p)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: for each instance, the cycle at which level falls and at which the guard ends.
  int fall_m[2];
  int gend_m[2];
  bit pend_m[2];
  bit ovr_m[2];

  function automatic logic [7:0] obs();
    return {lvl_r, busy_r, pend_r, ovr_r, lvl_p, busy_p, pend_p, ovr_p};
  endfunction

  function automatic logic [7:0] expv();
    logic [7:0] v;
    for (int i = 0; i < 2; i++) begin
      v[7-4*i]   = (cyc < fall_m[i]);
      v[6-4*i]   = (cyc < gend_m[i]);
      v[5-4*i]   = pend_m[i];
      v[4-4*i]   = ovr_m[i];
    end
    return v;
  endfunction

  task automatic model_step(input bit t, input bit r);
    for (int i = 0; i < 2; i++) begin
      bit retrig;
      retrig   = (i == 0);
      ovr_m[i] = 1'b0;
      if (!r) begin
        fall_m[i] = 0;
        gend_m[i] = 0;
        pend_m[i] = 1'b0;
      end else if (cyc >= gend_m[i]) begin
        if (t) begin
          fall_m[i] = cyc + 1 + HOLD;
          gend_m[i] = fall_m[i] + GAP;
        end
      end else if (cyc < fall_m[i]) begin
        if (t) begin
          if (retrig) begin
            fall_m[i] = cyc + 1 + HOLD;
            gend_m[i] = fall_m[i] + GAP;
          end else if (!pend_m[i]) pend_m[i] = 1'b1;
          else                     ovr_m[i]  = 1'b1;
        end
      end else if (cyc == gend_m[i] - 1) begin
        if (pend_m[i] || t) begin
          fall_m[i] = cyc + 1 + HOLD;
          gend_m[i] = fall_m[i] + GAP;
          pend_m[i] = pend_m[i] && t;
        end
      end else if (t) begin
        if (!pend_m[i]) pend_m[i] = 1'b1;
        else            ovr_m[i]  = 1'b1;
      end
    end
    cyc = cyc + 1;
  endtask

  task automatic drive(input bit t, input bit r);
    @(negedge clk);
    tick = t;
    rstn = r;
    model_step(t, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0);
      n_checks++;
      if (obs() !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d dut=%b required=%b", cyc, obs(), 8'h00);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d dut=%b model=%b", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_single();
    int hi_cnt = 0;
    int busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      drive(k == 0, 1'b1);
      hi_cnt   += int'(lvl_p);
      busy_cnt += int'(busy_p);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL single cyc=%0d dut=%b model=%b", cyc, obs(), expv());
      end
    end
    n_checks++;
    if (hi_cnt != HOLD || busy_cnt != HOLD + GAP) begin
      n_fail++;
      $display("FAIL single_width high=%0d busy=%0d required %0d/%0d", hi_cnt, busy_cnt, HOLD, HOLD + GAP);
    end
  endtask

  // Tick patterns, bit 0 first: retrigger (offsets 0,3), pending (0,2), overrun (0,2,3).
  task automatic test_patterns();
    logic [15:0] pats [3];
    int ovr_cnt;
    pats[0] = 16'b0000_0000_0000_1001;
    pats[1] = 16'b0000_0000_0000_0101;
    pats[2] = 16'b0000_0000_0000_1101;
    for (int p = 0; p < 3; p++) begin
      ovr_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        drive(pats[p][k], 1'b1);
        ovr_cnt += int'(ovr_p);
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++;
          $display("FAIL pattern%0d cyc=%0d dut=%b model=%b", p, cyc, obs(), expv());
        end
      end
      n_checks++;
      if (ovr_cnt != ((p == 2) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL pattern%0d_overrun count=%0d required=%0d", p, ovr_cnt, (p == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit tk [12] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit rs [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int k = 0; k < 12; k++) begin
      drive(tk[k], rs[k]);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_mid cyc=%0d dut=%b model=%b", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 30; k++) begin
      drive(k < 20, 1'b1);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d dut=%b model=%b", cyc, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit t, r;
    for (int k = 0; k < 800; k++) begin
      r = ($urandom_range(0, 59) != 0);
      t = ($urandom_range(0, 99) < 35);
      drive(t, r);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random cyc=%0d tick=%0b rstn=%0b dut=%b model=%b", cyc, t, r, obs(), expv());
      end
    end
  endtask

  initial begin
    tick = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fall_m[i] = 0;
      gend_m[i] = 0;
      pend_m[i] = 1'b0;
      ovr_m[i]  = 1'b0;
    end
    test_reset();
    test_single();
    test_patterns();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
